processor_core: RTL and testbench

PROCESSOR_CORE -- requirements
Module: processor

---
 rtl/processor_core_pkg.sv | 56 +++++
 rtl/processor_core_regfile.sv | 43 ++++
 rtl/processor_core_stage.sv | 151 +++++++++++++++
 rtl/processor_core.sv | 31 +++
 tb/tb_processor_core.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/processor_core_pkg.sv
// Shared encodings for the 2-stage processor core: instruction classes,
// per-class func codes, instruction field positions, the NOP encoding and
// the prefetch buffer record.
package processor_core_pkg;

  typedef enum logic [1:0] {
    CLS_R = 2'b00,
    CLS_I = 2'b01,
    CLS_J = 2'b10,
    CLS_B = 2'b11
  } cls_e;

  typedef enum logic [2:0] {
    F_NAND = 3'b000,
    F_XOR  = 3'b001,
    F_SLL  = 3'b010,
    F_SRL  = 3'b011,
    F_SRA  = 3'b100,
    F_ADD  = 3'b101,
    F_SUB  = 3'b110,
    F_NOP  = 3'b111
  } rfunc_e;

  typedef enum logic [1:0] {
    FI_LUI = 2'b00,
    FI_LBI = 2'b01,
    FI_SUI = 2'b10,
    FI_SBI = 2'b11
  } ifunc_e;

  localparam logic [2:0] FJ_JMP = 3'b000;
  localparam logic [2:0] FJ_JR  = 3'b001;

  // Field positions. The [13:11] field is rd (R/I), reg (J) or rs (B);
  // the [10:8] field is rs (R) or rt (B).
  localparam int CLS_HI  = 15, CLS_LO  = 14;
  localparam int F13_HI  = 13, F13_LO  = 11;
  localparam int F10_HI  = 10, F10_LO  = 8;
  localparam int RT_HI   = 7,  RT_LO   = 5;
  localparam int RFN_HI  = 2,  RFN_LO  = 0;
  localparam int IMM6_HI = 10, IMM6_LO = 5;
  localparam int IFN_HI  = 1,  IFN_LO  = 0;
  localparam int IMM8_HI = 10, IMM8_LO = 3;
  localparam int JFN_HI  = 2,  JFN_LO  = 0;
  localparam int OFF5_HI = 7,  OFF5_LO = 3;

  // R-class with func=NOP, all other fields zero.
  localparam logic [15:0] INST_NOP = 16'h0007;

  typedef struct packed {
    logic [15:0] inst;
    logic [7:0]  inst_pc;
    logic        valid;
  } pbuf_t;

endpackage

// File: rtl/processor_core_regfile.sv
// 8-entry register file, two combinational read ports, one write port.
// Also records the last written address (rd_last) and data (data_in).
// Ports: clk, rst (async high), i_ra_a/i_ra_b read addresses,
//        o_rd_a/o_rd_b read data, i_we/i_wa/i_wd write port,
//        o_rd_last/o_data_in last-write record.
module processor_core_regfile #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        i_ra_a,
  input  logic [2:0]        i_ra_b,
  output logic [DATA_W-1:0] o_rd_a,
  output logic [DATA_W-1:0] o_rd_b,
  input  logic              i_we,
  input  logic [2:0]        i_wa,
  input  logic [DATA_W-1:0] i_wd,
  output logic [2:0]        o_rd_last,
  output logic [DATA_W-1:0] o_data_in
);

  logic [DATA_W-1:0] r_regs [8];
  logic [2:0]        rd_last;
  logic [DATA_W-1:0] data_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
      rd_last <= '0;
      data_in <= '0;
    end else if (i_we) begin
      r_regs[i_wa] <= i_wd;
      rd_last      <= i_wa;
      data_in      <= i_wd;
    end
  end

  assign o_rd_a    = r_regs[i_ra_a];
  assign o_rd_b    = r_regs[i_ra_b];
  assign o_rd_last = rd_last;
  assign o_data_in = data_in;

endmodule

// File: rtl/processor_core_stage.sv
// Fetch + decode/execute/writeback stage. Holds PC_out, the instruction
// memory and the prefetch buffer; executes the buffered instruction in the
// same cycle the next one is fetched.
// Ports: clk, rst (async high), i_write load strobe, i_exinst instruction
//        pair, o_pc current PC_out, o_inst buffered instruction.
module processor_core_stage
  import processor_core_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int DATA_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_write,
  input  logic [31:0] i_exinst,
  output logic [7:0]  o_pc,
  output logic [15:0] o_inst
);

  localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

  logic [7:0]  PC_out;
  pbuf_t       PrefetchBuffer;
  logic [15:0] r_imem [IMEM_DEPTH];

  logic [7:0]        w_pc_nxt;
  logic [15:0]       w_fetch;
  logic [15:0]       w_inst;
  logic              w_exec;
  cls_e              w_cls;
  logic [2:0]        w_ra_a, w_ra_b;
  logic [DATA_W-1:0] w_a, w_b;
  logic [5:0]        w_imm6;
  logic [7:0]        w_imm8;
  logic [4:0]        w_off5;
  logic [DATA_W-1:0] w_sext6, w_zext6;
  logic              w_we;
  logic [2:0]        w_wa;
  logic [DATA_W-1:0] w_wd;
  logic              w_redirect;
  logic [7:0]        w_target;
  logic [2:0]        w_rd_last;
  logic [DATA_W-1:0] w_data_in;

  assign w_pc_nxt = PC_out + 8'd1;

  // Instruction memory is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (i_write) begin
      r_imem[AW'(PC_out)]   <= i_exinst[15:0];
      r_imem[AW'(w_pc_nxt)] <= i_exinst[31:16];
    end
  end

  assign w_fetch = r_imem[AW'(PC_out)];

  // A load cycle suppresses execution of whatever sits in the buffer.
  assign w_inst = PrefetchBuffer.inst;
  assign w_exec = PrefetchBuffer.valid & ~i_write;
  assign w_cls  = cls_e'(w_inst[CLS_HI:CLS_LO]);
  assign w_ra_a = (w_cls == CLS_R) ? w_inst[F10_HI:F10_LO] : w_inst[F13_HI:F13_LO];
  assign w_ra_b = (w_cls == CLS_R) ? w_inst[RT_HI:RT_LO]   : w_inst[F10_HI:F10_LO];

  assign w_imm6  = w_inst[IMM6_HI:IMM6_LO];
  assign w_imm8  = w_inst[IMM8_HI:IMM8_LO];
  assign w_off5  = w_inst[OFF5_HI:OFF5_LO];
  assign w_sext6 = {{(DATA_W-6){w_imm6[5]}}, w_imm6};
  assign w_zext6 = {{(DATA_W-6){1'b0}}, w_imm6};

  processor_core_regfile #(.DATA_W(DATA_W)) Registers (
    .clk       (clk),
    .rst       (rst),
    .i_ra_a    (w_ra_a),
    .i_ra_b    (w_ra_b),
    .o_rd_a    (w_a),
    .o_rd_b    (w_b),
    .i_we      (w_we),
    .i_wa      (w_wa),
    .i_wd      (w_wd),
    .o_rd_last (w_rd_last),
    .o_data_in (w_data_in)
  );

  always_comb begin
    w_we       = 1'b0;
    w_wa       = w_inst[F13_HI:F13_LO];
    w_wd       = w_a;
    w_redirect = 1'b0;
    w_target   = w_pc_nxt;
    case (w_cls)
      CLS_R: begin
        w_we = w_exec && (rfunc_e'(w_inst[RFN_HI:RFN_LO]) != F_NOP);
        case (rfunc_e'(w_inst[RFN_HI:RFN_LO]))
          F_NAND:  w_wd = ~(w_a & w_b);
          F_XOR:   w_wd = w_a ^ w_b;
          F_SLL:   w_wd = w_a << w_b[3:0];
          F_SRL:   w_wd = w_a >> w_b[3:0];
          F_SRA:   w_wd = $signed(w_a) >>> w_b[3:0];
          F_ADD:   w_wd = w_a + w_b;
          F_SUB:   w_wd = w_a - w_b;
          default: w_wd = w_a;
        endcase
      end
      CLS_I: begin
        w_we = w_exec;
        case (ifunc_e'(w_inst[IFN_HI:IFN_LO]))
          FI_LUI: w_wd = {w_imm6, w_a[DATA_W-7:0]};
          FI_LBI: w_wd = w_sext6;
          FI_SUI: w_wd = w_a - w_zext6;
          FI_SBI: w_wd = w_a + w_sext6;
          default: w_wd = w_a;
        endcase
      end
      CLS_J: begin
        if (w_inst[JFN_HI:JFN_LO] == FJ_JMP) begin
          w_redirect = w_exec;
          w_target   = PrefetchBuffer.inst_pc + w_imm8;
        end else if (w_inst[JFN_HI:JFN_LO] == FJ_JR) begin
          w_redirect = w_exec;
          w_target   = w_a[7:0] + w_imm8;
        end
      end
      CLS_B: begin
        w_redirect = w_exec && (w_a != w_b);
        w_target   = PrefetchBuffer.inst_pc + {{3{w_off5[4]}}, w_off5};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC_out         <= '0;
      PrefetchBuffer <= '0;
    end else if (i_write) begin
      PrefetchBuffer.valid <= 1'b0;
    end else if (w_redirect) begin
      PC_out               <= w_target;
      PrefetchBuffer.valid <= 1'b0;
    end else begin
      PrefetchBuffer.inst    <= w_fetch;
      PrefetchBuffer.inst_pc <= PC_out;
      PrefetchBuffer.valid   <= 1'b1;
      PC_out                 <= w_pc_nxt;
    end
  end

  assign o_pc   = PC_out;
  assign o_inst = PrefetchBuffer.inst;

endmodule

// File: rtl/processor_core.sv
// 2-stage 16-bit processor core top level.
// Ports: clk, rst (async high), write load/stall strobe, exInst instruction
//        pair ([15:0] -> PC, [31:16] -> PC+1), pc_dbg current PC,
//        inst_dbg prefetch-buffer instruction.
module processor_core
  import processor_core_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int DATA_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write,
  input  logic [31:0] exInst,
  output logic [7:0]  pc_dbg,
  output logic [15:0] inst_dbg
);

  processor_core_stage #(
    .IMEM_DEPTH (IMEM_DEPTH),
    .DATA_W     (DATA_W)
  ) I1 (
    .clk      (clk),
    .rst      (rst),
    .i_write  (write),
    .i_exinst (exInst),
    .o_pc     (pc_dbg),
    .o_inst   (inst_dbg)
  );

endmodule

// File: tb/tb_processor_core.sv
module tb_processor_core;

  logic        clk;
  logic        rst;
  logic        write;
  logic [31:0] exInst;
  logic [7:0]  pc_dbg;
  logic [15:0] inst_dbg;

  int checks;
  int errors;

  logic [15:0] prog [64];
  int          plen;

  localparam logic [15:0] NOP  = 16'h0007;
  localparam logic [15:0] HALT = 16'h8000;   // JMP +0: spin in place

  processor_core #(.IMEM_DEPTH(256), .DATA_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .write    (write),
    .exInst   (exInst),
    .pc_dbg   (pc_dbg),
    .inst_dbg (inst_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] enc_r(logic [2:0] rd, logic [2:0] rs, logic [2:0] rt, logic [2:0] f);
    return {2'b00, rd, rs, rt, 2'b00, f};
  endfunction
  function automatic logic [15:0] enc_i(logic [2:0] rd, logic [5:0] imm, logic [1:0] f);
    return {2'b01, rd, imm, 3'b000, f};
  endfunction
  function automatic logic [15:0] enc_j(logic [2:0] rg, logic [7:0] imm, logic [2:0] f);
    return {2'b10, rg, imm, f};
  endfunction
  function automatic logic [15:0] enc_b(logic [2:0] rs, logic [2:0] rt, logic [4:0] off);
    return {2'b11, rs, rt, off, 3'b000};
  endfunction

  function automatic logic [15:0] rf(int i);
    return dut.I1.Registers.r_regs[i];
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic add(logic [15:0] w);
    prog[plen] = w;
    plen++;
  endtask

  // Loads prog[] through the write port: write the pair at PC, then one
  // fetch cycle to advance PC (the fetched word is flushed by the next
  // write). A final reset restarts execution at 0 with imem intact.
  task automatic load_prog();
    pulse_reset();
    for (int i = 0; i < plen; i++) begin
      write  = 1'b1;
      exInst = {(i + 1 < plen) ? prog[i+1] : NOP, prog[i]};
      step(1);
      write  = 1'b0;
      step(1);
    end
    exInst = '0;
    pulse_reset();
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++; if (pc_dbg !== 8'h00) begin errors++; $display("FAIL reset_pc got %h exp 00", pc_dbg); end
    checks++; if (inst_dbg !== 16'h0000) begin errors++; $display("FAIL reset_inst got %h exp 0000", inst_dbg); end
    checks++; if (dut.I1.PrefetchBuffer.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", dut.I1.PrefetchBuffer.valid); end
    step(2);
    for (int i = 0; i < 8; i++) begin
      checks++; if (rf(i) !== 16'h0000) begin errors++; $display("FAIL reset_r%0d got %h exp 0000", i, rf(i)); end
    end
    checks++; if (pc_dbg !== 8'h00) begin errors++; $display("FAIL reset_hold_pc got %h exp 00", pc_dbg); end
    rst = 1'b0;
  endtask

  task automatic test_load_run();
    write  = 1'b1;
    exInst = {16'h4820, 16'h4001};
    step(1);
    checks++; if (pc_dbg !== 8'h00) begin errors++; $display("FAIL load_pc got %h exp 00", pc_dbg); end
    write  = 1'b0;
    exInst = '0;
    step(1);
    checks++; if (pc_dbg !== 8'h01) begin errors++; $display("FAIL load_fetch_pc got %h exp 01", pc_dbg); end
    checks++; if (inst_dbg !== 16'h4001) begin errors++; $display("FAIL load_fetch_inst got %h exp 4001", inst_dbg); end
    step(2);
    checks++; if (rf(0) !== 16'h0000) begin errors++; $display("FAIL load_r0 got %h exp 0000", rf(0)); end
    checks++; if (rf(1) !== 16'h0400) begin errors++; $display("FAIL load_r1 got %h exp 0400", rf(1)); end
    checks++; if (dut.I1.Registers.rd_last !== 3'd1) begin errors++; $display("FAIL load_rd_last got %0d exp 1", dut.I1.Registers.rd_last); end
    checks++; if (dut.I1.Registers.data_in !== 16'h0400) begin errors++; $display("FAIL load_data_in got %h exp 0400", dut.I1.Registers.data_in); end
  endtask

  task automatic test_alu();
    int          idx [5];
    logic [15:0] exp [5];
    idx = '{4, 5, 0, 1, 6};
    exp = '{16'h0002, 16'h0008, 16'hFFF8, 16'hFFFA, 16'hA000};
    plen = 0;
    add(enc_i(3'd2, 6'd5, 2'b01));           // LBI r2,5
    add(enc_i(3'd3, 6'h3D, 2'b01));          // LBI r3,-3
    add(enc_r(3'd4, 3'd2, 3'd3, 3'b101));    // ADD
    add(enc_r(3'd5, 3'd2, 3'd3, 3'b110));    // SUB
    add(enc_r(3'd0, 3'd2, 3'd3, 3'b001));    // XOR
    add(enc_r(3'd1, 3'd2, 3'd3, 3'b000));    // NAND
    add(enc_r(3'd6, 3'd2, 3'd3, 3'b010));    // SLL by 13
    add(enc_i(3'd4, 6'd0, 2'b01));           // LBI r4,0
    add(enc_i(3'd4, 6'h20, 2'b00));          // LUI r4 -> 8000
    add(enc_i(3'd7, 6'd1, 2'b01));           // LBI r7,1
    add(enc_r(3'd5, 3'd4, 3'd7, 3'b100));    // SRA
    add(HALT);
    load_prog();
    step(8);
    for (int i = 0; i < 5; i++) begin
      checks++; if (rf(idx[i]) !== exp[i]) begin errors++; $display("FAIL alu_%0d r%0d got %h exp %h", i, idx[i], rf(idx[i]), exp[i]); end
    end
    step(4);
    checks++; if (rf(4) !== 16'h8000) begin errors++; $display("FAIL alu_lui got %h exp 8000", rf(4)); end
    checks++; if (rf(5) !== 16'hC000) begin errors++; $display("FAIL alu_sra got %h exp C000", rf(5)); end
  endtask

  // Runs on the ALU program still in imem.
  task automatic test_stall();
    logic [15:0] w0, w1;
    w0 = enc_i(3'd3, 6'd7, 2'b01);    // LBI r3,7
    w1 = enc_i(3'd6, 6'h20, 2'b01);   // LBI r6,-32
    pulse_reset();
    step(2);
    checks++; if (pc_dbg !== 8'h02) begin errors++; $display("FAIL stall_pre_pc got %h exp 02", pc_dbg); end
    write  = 1'b1;
    exInst = {w1, w0};
    for (int c = 0; c < 3; c++) begin
      step(1);
      checks++; if (pc_dbg !== 8'h02) begin errors++; $display("FAIL stall_pc_%0d got %h exp 02", c, pc_dbg); end
      checks++; if (rf(3) !== 16'h0000) begin errors++; $display("FAIL stall_r3_%0d got %h exp 0000", c, rf(3)); end
    end
    write  = 1'b0;
    exInst = '0;
    checks++; if (rf(2) !== 16'h0005) begin errors++; $display("FAIL stall_r2 got %h exp 0005", rf(2)); end
    checks++; if (dut.I1.r_imem[2] !== w0) begin errors++; $display("FAIL stall_imem2 got %h exp %h", dut.I1.r_imem[2], w0); end
    checks++; if (dut.I1.r_imem[3] !== w1) begin errors++; $display("FAIL stall_imem3 got %h exp %h", dut.I1.r_imem[3], w1); end
    step(3);
    checks++; if (rf(3) !== 16'h0007) begin errors++; $display("FAIL stall_run_r3 got %h exp 0007", rf(3)); end
    checks++; if (rf(6) !== 16'hFFE0) begin errors++; $display("FAIL stall_run_r6 got %h exp FFE0", rf(6)); end
  endtask

  task automatic test_branch();
    plen = 0;
    add(enc_i(3'd1, 6'd4, 2'b01));           // 0 LBI r1,4
    add(enc_i(3'd2, 6'd4, 2'b01));           // 1 LBI r2,4
    add(enc_b(3'd1, 3'd2, 5'b01110));        // 2 BNE equal: not taken
    add(enc_i(3'd3, 6'd1, 2'b01));           // 3 LBI r3,1
    add(enc_i(3'd2, 6'd5, 2'b01));           // 4 LBI r2,5
    add(enc_b(3'd1, 3'd2, 5'b01110));        // 5 BNE taken -> 19
    add(enc_i(3'd4, 6'd1, 2'b01));           // 6 must be skipped
    for (int i = 7; i < 19; i++) add(enc_i(3'd5, 6'd1, 2'b01));
    add(enc_j(3'd0, 8'h01, 3'b000));         // 19 JMP +1
    add(enc_i(3'd6, 6'd2, 2'b01));           // 20 LBI r6,2
    add(HALT);                               // 21
    load_prog();
    step(4);
    checks++; if (pc_dbg !== 8'h04) begin errors++; $display("FAIL bne_nt_pc got %h exp 04", pc_dbg); end
    step(3);
    checks++; if (pc_dbg !== 8'h13) begin errors++; $display("FAIL bne_t_pc got %h exp 13", pc_dbg); end
    checks++; if (dut.I1.PrefetchBuffer.valid !== 1'b0) begin errors++; $display("FAIL bne_flush got %b exp 0", dut.I1.PrefetchBuffer.valid); end
    step(2);
    checks++; if (pc_dbg !== 8'h14) begin errors++; $display("FAIL jmp_pc got %h exp 14", pc_dbg); end
    step(2);
    checks++; if (rf(3) !== 16'h0001) begin errors++; $display("FAIL br_r3 got %h exp 0001", rf(3)); end
    checks++; if (rf(4) !== 16'h0000) begin errors++; $display("FAIL br_r4 got %h exp 0000", rf(4)); end
    checks++; if (rf(5) !== 16'h0000) begin errors++; $display("FAIL br_r5 got %h exp 0000", rf(5)); end
    checks++; if (rf(6) !== 16'h0002) begin errors++; $display("FAIL br_r6 got %h exp 0002", rf(6)); end
  endtask

  // Follows test_branch: registers are nonzero here.
  task automatic test_reset_midrun();
    rst = 1'b1;
    #1;
    checks++; if (pc_dbg !== 8'h00) begin errors++; $display("FAIL mid_rst_pc got %h exp 00", pc_dbg); end
    checks++; if (dut.I1.PrefetchBuffer.valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", dut.I1.PrefetchBuffer.valid); end
    checks++; if (rf(6) !== 16'h0000) begin errors++; $display("FAIL mid_rst_r6 got %h exp 0000", rf(6)); end
    checks++; if (rf(2) !== 16'h0000) begin errors++; $display("FAIL mid_rst_r2 got %h exp 0000", rf(2)); end
    checks++; if (dut.I1.Registers.data_in !== 16'h0000) begin errors++; $display("FAIL mid_rst_data_in got %h exp 0000", dut.I1.Registers.data_in); end
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_jr();
    plen = 0;
    add(enc_i(3'd5, 6'd31, 2'b01));          // LBI r5,31
    add(enc_i(3'd5, 6'd1, 2'b11));           // SBI r5,+1 -> 0x20
    add(enc_j(3'd5, 8'h00, 3'b001));         // JR r5
    add(enc_i(3'd1, 6'd1, 2'b01));           // discarded
    add(HALT);
    load_prog();
    step(4);
    checks++; if (pc_dbg !== 8'h20) begin errors++; $display("FAIL jr_pc got %h exp 20", pc_dbg); end
    write  = 1'b1;
    exInst = {HALT, enc_i(3'd5, 6'd2, 2'b10)};   // SUI r5,2 at 0x20
    step(1);
    write  = 1'b0;
    exInst = '0;
    step(2);
    checks++; if (rf(5) !== 16'h001E) begin errors++; $display("FAIL jr_sui_r5 got %h exp 001E", rf(5)); end
    checks++; if (rf(1) !== 16'h0000) begin errors++; $display("FAIL jr_r1 got %h exp 0000", rf(1)); end
  endtask

  task automatic test_wrap();
    logic [15:0] w1;
    w1 = enc_i(3'd4, 6'h3F, 2'b01);          // LBI r4,-1
    plen = 0;
    add(enc_j(3'd0, 8'hFE, 3'b000));         // JMP -2 -> 0xFE
    add(HALT);
    load_prog();
    step(2);
    checks++; if (pc_dbg !== 8'hFE) begin errors++; $display("FAIL wrap_jmp_pc got %h exp FE", pc_dbg); end
    write  = 1'b1;
    exInst = {w1, enc_i(3'd3, 6'd3, 2'b01)};
    step(1);
    write  = 1'b0;
    exInst = '0;
    step(1);
    checks++; if (pc_dbg !== 8'hFF) begin errors++; $display("FAIL wrap_pc_ff got %h exp FF", pc_dbg); end
    step(1);
    checks++; if (pc_dbg !== 8'h00) begin errors++; $display("FAIL wrap_pc_00 got %h exp 00", pc_dbg); end
    checks++; if (inst_dbg !== w1) begin errors++; $display("FAIL wrap_inst got %h exp %h", inst_dbg, w1); end
    step(1);
    checks++; if (rf(3) !== 16'h0003) begin errors++; $display("FAIL wrap_r3 got %h exp 0003", rf(3)); end
    checks++; if (rf(4) !== 16'hFFFF) begin errors++; $display("FAIL wrap_r4 got %h exp FFFF", rf(4)); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    plen   = 0;
    rst    = 1'b0;
    write  = 1'b0;
    exInst = '0;
    test_reset();
    test_load_run();
    test_alu();
    test_stall();
    test_branch();
    test_reset_midrun();
    test_jr();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
